obuf_drain_ctrl: RTL and testbench
==================================

Name: obuf_drain_ctrl

Overview:
Sequences read-out of the output buffer after a compute tile has been written. It walks a rectangular region of the per-column output RAMs in row-major order by driving the buffer's ram_idx/read_addr. Read data is streamed to the downstream DMA/host over a valid/ready interface. It sits between the top-level NPU controller (start/done) and the output buffer's read port.

Parameters:
ARRAY_M, 8, number of output RAMs (systolic columns)
RAM_SIZE, 256, depth of each output RAM
ADDR_WIDTH, $clog2(RAM_SIZE), RAM address width
DATA_WIDTH, 32, read data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to drain a region; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first row address; latched on accepted start
num_rows  in  ADDR_WIDTH+1  rows to drain (0..RAM_SIZE); latched on start
num_cols  in  $clog2(ARRAY_M)+1  columns per row (0..ARRAY_M); latched on start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle completion pulse
ram_idx  out  $clog2(ARRAY_M)  RAM select to the output buffer
read_addr  out  ADDR_WIDTH  read address to the output buffer
data_read  in  DATA_WIDTH  buffer read data, valid 1 cycle after ram_idx/read_addr are presented
out_valid  out  1  stream data valid
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  stream data
out_last  out  1  marks the final word of the region

Behaviour:
- The only clock is clk. reset is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_idx=0, read_addr=0. The FIFO and in-flight tracking are cleared.
- Reset mid-operation aborts the drain immediately. No done pulse is produced.
- Order: for r in 0..num_rows-1, for c in 0..num_cols-1, issue ram_idx=c, read_addr=(base_addr+r) mod 2^ADDR_WIDTH. Address wrap past RAM_SIZE-1 to 0 is legal.
- num_cols>ARRAY_M is clamped to ARRAY_M at latch time.
- States: IDLE, RUN, FLUSH.
  - IDLE + start with num_rows==0 or num_cols==0: done=1 next cycle, busy stays 0, no output.
  - IDLE + valid start: latch config, go to RUN, busy=1.
  - RUN: at most one read issued per cycle when credit allows. When the last (r,c) is issued, go to FLUSH.
  - FLUSH: wait until the in-flight read has returned and the FIFO is empty (last word handshaken). Then, in the next cycle, done=1 and busy=0, and the state returns to IDLE.
- start while busy is ignored.
- Read return path: data_read is captured into a 2-entry FIFO exactly 1 cycle after issue. The FIFO head drives out_valid, out_data and out_last, all registered.
- Credit: a read may issue only if (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready. This must never overflow under arbitrary out_ready patterns.
- Handshake: a word transfers when out_valid & out_ready. Once out_valid is asserted, out_data and out_last hold stable until the transfer.
- ram_idx/read_addr hold their last value when no read is issued.
- Latency with out_ready=1: start sampled at edge 0; first address issued in cycle 1; first out_valid in cycle 3.
- Throughput is 1 word/cycle. The last handshake is in cycle 2+R·C, and done is in cycle 3+R·C.
- out_last is high only for word R·C−1.

Test Plan:
- Basic drain: base_addr=0x10, num_rows=2, num_cols=3, out_ready=1, RAM m addr a preloaded with {m,a} → 6 words in order (0,0x10),(1,0x10),(2,0x10),(0,0x11),(1,0x11),(2,0x11); out_last on the 6th; first out_valid at cycle 3; done at cycle 9.
- Backpressure: num_rows=4, num_cols=8, out_ready toggling 1010… plus a 10-cycle low stretch → all 32 words delivered exactly once, in order; out_data stable while stalled; FIFO never exceeds 2 entries.
- Wrap: base_addr=0xFE, num_rows=4, num_cols=1 → addresses 0xFE,0xFF,0x00,0x01.
- Degenerate/clamp: num_rows=0 → done at cycle 1, no out_valid. num_cols=15, num_rows=1 → 8 words (ram_idx 0..7).
- Start while busy: a second start pulse mid-drain → ignored, only the first region is streamed, single done pulse.
- Reset mid-drain: assert reset after 5 words → next cycle all outputs 0, state IDLE, no done. A subsequent start drains a fresh region correctly.

Source files
------------

// File: rtl/obuf_drain_ctrl.sv
// ----------------------------------------------------------------------------
// obuf_drain_ctrl
//
// Drains a rectangular region of the per-column output RAMs after a compute
// tile has been written. The region is walked in row-major order: for each row
// r the columns 0..num_cols-1 are read at address base_addr + r (wrapping mod
// 2^ADDR_WIDTH). Returned words go through a 2-entry FIFO whose head drives a
// valid/ready stream towards the DMA/host.
//
// Ports
//   i_clk          clock
//   i_reset        synchronous, active-high reset
//   i_start        one-cycle drain request, only honoured while idle
//   i_base_addr    first row address (latched on an accepted start)
//   i_num_rows     rows to drain, 0..RAM_SIZE (latched on start)
//   i_num_cols     columns per row, 0..ARRAY_M, larger values clamp to ARRAY_M
//   o_busy         high from the cycle after an accepted start until done
//   o_done         one-cycle completion pulse
//   o_ram_idx      RAM select to the output buffer
//   o_read_addr    read address to the output buffer
//   i_data_read    buffer read data, valid one cycle after the address
//   o_out_valid    stream valid
//   i_out_ready    stream ready
//   o_out_data     stream data
//   o_out_last     marks the final word of the region
// ----------------------------------------------------------------------------
module obuf_drain_ctrl #(
    parameter int unsigned ARRAY_M    = 8,
    parameter int unsigned RAM_SIZE   = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [ADDR_WIDTH-1:0]       i_base_addr,
    input  logic [ADDR_WIDTH:0]         i_num_rows,
    input  logic [$clog2(ARRAY_M):0]    i_num_cols,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(ARRAY_M)-1:0]  o_ram_idx,
    output logic [ADDR_WIDTH-1:0]       o_read_addr,
    input  logic [DATA_WIDTH-1:0]       i_data_read,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [DATA_WIDTH-1:0]       o_out_data,
    output logic                        o_out_last
);

    localparam int unsigned IDX_W = $clog2(ARRAY_M);
    localparam int unsigned COL_W = IDX_W + 1;
    localparam int unsigned ROW_W = ADDR_WIDTH + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [COL_W-1:0] LP_COLS_MAX = COL_W'(ARRAY_M);
    localparam logic [COL_W-1:0] LP_COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] LP_ROW_ONE  = ROW_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic                   r_busy;
    logic                   r_done;

    // Latched region shape and walk position (next read to issue)
    logic [ROW_W-1:0]       r_rows;
    logic [COL_W-1:0]       r_cols;
    logic [ROW_W-1:0]       r_row_cnt;
    logic [COL_W-1:0]       r_col_cnt;
    logic [ADDR_WIDTH-1:0]  r_row_addr;

    // Address held on the buffer port when no read is being issued
    logic [IDX_W-1:0]       r_last_idx;
    logic [ADDR_WIDTH-1:0]  r_last_addr;

    // Read issued last cycle: its data is on i_data_read this cycle
    logic                   r_inflight;
    logic                   r_inflight_last;

    // 2-entry FIFO: head entry drives the stream directly, tail is the spare
    logic                   r_head_valid;
    logic [DATA_WIDTH-1:0]  r_head_data;
    logic                   r_head_last;
    logic                   r_tail_valid;
    logic [DATA_WIDTH-1:0]  r_tail_data;
    logic                   r_tail_last;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [COL_W-1:0]       w_cols_clamped;
    logic                   w_start_empty;
    logic                   w_pop;
    logic [1:0]             w_occupancy;
    logic [1:0]             w_occ_after_pop;
    logic                   w_credit;
    logic                   w_issue;
    logic                   w_col_end;
    logic                   w_row_end;
    logic                   w_issue_last;
    logic                   w_fifo_drained;

    assign w_cols_clamped = (i_num_cols > LP_COLS_MAX) ? LP_COLS_MAX : i_num_cols;
    assign w_start_empty  = (i_num_rows == '0) || (i_num_cols == '0);

    assign w_pop = r_head_valid & i_out_ready;

    // Everything already committed to land in the FIFO. Head + tail + in-flight
    // never exceeds 2 after any edge, so 2 bits are enough.
    assign w_occupancy     = {1'b0, r_head_valid} + {1'b0, r_tail_valid} + {1'b0, r_inflight};
    assign w_occ_after_pop = w_occupancy - {1'b0, w_pop};
    assign w_credit        = (w_occ_after_pop < 2'd2);

    // The issue decision is made in the same cycle the address is presented.
    // Counting this cycle's pop is what lets a 2-entry FIFO sustain one word
    // per cycle, at the price of a combinational path from i_out_ready to the
    // buffer address.
    assign w_issue = (r_state == ST_RUN) && w_credit;

    assign w_col_end    = (r_col_cnt == (r_cols - LP_COL_ONE));
    assign w_row_end    = (r_row_cnt == (r_rows - LP_ROW_ONE));
    assign w_issue_last = w_col_end && w_row_end;

    assign o_ram_idx   = w_issue ? r_col_cnt[IDX_W-1:0] : r_last_idx;
    assign o_read_addr = w_issue ? r_row_addr : r_last_addr;

    // Last word handshaken (or handshaking now) and nothing left in the pipe
    assign w_fifo_drained = !r_inflight && !r_tail_valid && (!r_head_valid || w_pop);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_rows          <= '0;
            r_cols          <= '0;
            r_row_cnt       <= '0;
            r_col_cnt       <= '0;
            r_row_addr      <= '0;
            r_last_idx      <= '0;
            r_last_addr     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;

            if (w_issue) begin
                r_last_idx  <= r_col_cnt[IDX_W-1:0];
                r_last_addr <= r_row_addr;
                if (w_col_end) begin
                    r_col_cnt  <= '0;
                    r_row_cnt  <= r_row_cnt + LP_ROW_ONE;
                    // Natural wrap of the address width is the intended behaviour
                    r_row_addr <= r_row_addr + ADDR_WIDTH'(1);
                end else begin
                    r_col_cnt  <= r_col_cnt + LP_COL_ONE;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_start_empty) begin
                            // Empty region: complete immediately, never go busy
                            r_done <= 1'b1;
                        end else begin
                            r_rows     <= i_num_rows;
                            r_cols     <= w_cols_clamped;
                            r_row_cnt  <= '0;
                            r_col_cnt  <= '0;
                            r_row_addr <= i_base_addr;
                            r_busy     <= 1'b1;
                            r_state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_fifo_drained) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Return FIFO
    // ------------------------------------------------------------------
    // Capture happens unconditionally when r_inflight is set; the credit check
    // guarantees there is always room for it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_head_last  <= 1'b0;
            r_tail_valid <= 1'b0;
            r_tail_data  <= '0;
            r_tail_last  <= 1'b0;
        end else if (!r_head_valid || w_pop) begin
            // Head is free (or being freed): refill from tail, else from the RAM
            if (r_tail_valid) begin
                r_head_valid <= 1'b1;
                r_head_data  <= r_tail_data;
                r_head_last  <= r_tail_last;
                r_tail_valid <= r_inflight;
                if (r_inflight) begin
                    r_tail_data <= i_data_read;
                    r_tail_last <= r_inflight_last;
                end
            end else begin
                r_head_valid <= r_inflight;
                if (r_inflight) begin
                    r_head_data <= i_data_read;
                    r_head_last <= r_inflight_last;
                end
            end
        end else if (r_inflight) begin
            // Head stalled: it keeps its word stable, new word parks in tail
            r_tail_valid <= 1'b1;
            r_tail_data  <= i_data_read;
            r_tail_last  <= r_inflight_last;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_out_valid = r_head_valid;
    assign o_out_data  = r_head_data;
    assign o_out_last  = r_head_last;

endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_obuf_drain_ctrl
//
// Directed bench for obuf_drain_ctrl. Each region request pushes its expected
// words into a scoreboard queue; an independent negedge monitor pops and
// compares on every stream handshake and checks that stalled words stay put.
// The output RAMs are modelled as a synchronous read returning a word that
// encodes {ram index, address}.
// ----------------------------------------------------------------------------
module tb_obuf_drain_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_num_rows;
    logic [CW-1:0] i_num_cols;
    logic          o_busy;
    logic          o_done;
    logic [IW-1:0] o_ram_idx;
    logic [AW-1:0] o_read_addr;
    logic [DW-1:0] i_data_read;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [DW-1:0] o_out_data;
    logic          o_out_last;

    obuf_drain_ctrl #(
        .ARRAY_M    (8),
        .RAM_SIZE   (256),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_rows  (i_num_rows),
        .i_num_cols  (i_num_cols),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_idx   (o_ram_idx),
        .o_read_addr (o_read_addr),
        .i_data_read (i_data_read),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t0       = 0;
    int ready_mode = 0;

    // Monitor state
    int          done_cnt = 0;
    int          done_rel = -1;
    int          words    = 0;
    bit          seen_valid = 1'b0;
    int          first_valid_rel = -1;
    bit          held_valid = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [32:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(int m, int a);
        return 32'hD000_0000 | (32'(m) << 16) | 32'(a);
    endfunction

    // Synchronous-read output buffer model
    always @(posedge clk) i_data_read <= ram_word(int'(o_ram_idx), int'(o_read_addr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (o_done) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
        if (o_out_valid && !seen_valid) begin
            seen_valid = 1'b1;
            first_valid_rel = cyc - t0;
        end
        if (o_out_valid && i_out_ready) begin
            words++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_word: got data=%08h last=%0b, required no word",
                         o_out_data, o_out_last);
            end else begin
                e = exp_q.pop_front();
                check("word_data", o_out_data, e[31:0]);
                check("word_last", 32'(o_out_last), 32'(e[32]));
            end
            held_valid = 1'b0;
        end else if (o_out_valid) begin
            if (held_valid) begin
                check("stall_data_stable", o_out_data, held_data);
                check("stall_last_stable", 32'(o_out_last), 32'(held_last));
            end
            held_valid = 1'b1;
            held_data  = o_out_data;
            held_last  = o_out_last;
        end else begin
            held_valid = 1'b0;
        end
    end

    // Downstream ready: always 1, or 1010... with a 10-cycle low stretch
    initial begin
        i_out_ready = 1'b1;
        forever begin
            int rel;
            @(posedge clk);
            #1;
            rel = cyc - t0;
            if (ready_mode == 0) i_out_ready = 1'b1;
            else if (rel >= 8 && rel < 18) i_out_ready = 1'b0;
            else i_out_ready = (rel % 2 == 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_region(input int base, input int rows, input int cols);
        int c_eff;
        c_eff = (cols > 8) ? 8 : cols;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < c_eff; c++) begin
                logic last_bit;
                last_bit = ((r * c_eff + c) == (rows * c_eff - 1));
                exp_q.push_back({last_bit, ram_word(c, (base + r) % 256)});
            end
        end
    endtask

    // Start high during cycle 0 (relative time origin t0)
    task automatic pulse_start(input logic [AW-1:0] base, input logic [AW:0] rows,
                               input logic [CW-1:0] cols, input bit set_origin);
        @(posedge clk);
        #1;
        i_base_addr = base;
        i_num_rows  = rows;
        i_num_cols  = cols;
        i_start     = 1'b1;
        if (set_origin) begin
            t0 = cyc;
            seen_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt, input int budget);
        int n;
        n = 0;
        while (done_cnt == base_cnt && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == base_cnt) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(o_out_last), 32'd0);
        check({tag, "_out_data"}, o_out_data, 32'd0);
        check({tag, "_ram_idx"}, 32'(o_ram_idx), 32'd0);
        check({tag, "_read_addr"}, 32'(o_read_addr), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int n;
        i_reset     = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_num_rows  = '0;
        i_num_cols  = '0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        tick();
        check_all_zero("reset");

        // Basic drain 2x3 at 0x10
        d0 = done_cnt;
        push_region(16, 2, 3);
        pulse_start(8'h10, 9'd2, 4'd3, 1'b1);
        tick();
        check("basic_busy_cycle1", 32'(o_busy), 32'd1);
        wait_done(d0, 200);
        check("basic_first_valid_cycle", 32'(first_valid_rel), 32'd3);
        check("basic_done_cycle", 32'(done_rel), 32'd9);
        check("basic_busy_low_at_done", 32'(o_busy), 32'd0);
        check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure 4x8 at 0x20
        d0 = done_cnt;
        w0 = words;
        ready_mode = 1;
        push_region(32, 4, 8);
        pulse_start(8'h20, 9'd4, 4'd8, 1'b1);
        wait_done(d0, 2000);
        ready_mode = 0;
        check("bp_word_count", 32'(words - w0), 32'd32);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Address wrap
        d0 = done_cnt;
        push_region(254, 4, 1);
        pulse_start(8'hFE, 9'd4, 4'd1, 1'b1);
        wait_done(d0, 200);
        check("wrap_done_cycle", 32'(done_rel), 32'd7);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty regions: done at cycle 1, never busy, no output
        d0 = done_cnt;
        w0 = words;
        pulse_start(8'h05, 9'd0, 4'd3, 1'b1);
        tick();
        check("rows0_busy", 32'(o_busy), 32'd0);
        wait_done(d0, 10);
        check("rows0_done_cycle", 32'(done_rel), 32'd1);
        d0 = done_cnt;
        pulse_start(8'h05, 9'd3, 4'd0, 1'b1);
        wait_done(d0, 10);
        check("cols0_done_cycle", 32'(done_rel), 32'd1);
        repeat (5) tick();
        check("empty_no_words", 32'(words - w0), 32'd0);
        check("empty_no_valid", 32'(seen_valid), 32'd0);

        // Column clamp: 15 -> 8
        d0 = done_cnt;
        w0 = words;
        push_region(48, 1, 15);
        pulse_start(8'h30, 9'd1, 4'd15, 1'b1);
        wait_done(d0, 200);
        check("clamp_word_count", 32'(words - w0), 32'd8);
        check("clamp_done_cycle", 32'(done_rel), 32'd11);

        // Start while busy is ignored
        d0 = done_cnt;
        w0 = words;
        push_region(80, 2, 4);
        pulse_start(8'h50, 9'd2, 4'd4, 1'b1);
        repeat (2) @(posedge clk);
        pulse_start(8'h90, 9'd3, 4'd2, 1'b0);
        wait_done(d0, 200);
        repeat (20) tick();
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_start_word_count", 32'(words - w0), 32'd8);
        check("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset after 5 words
        d0 = done_cnt;
        w0 = words;
        push_region(96, 3, 4);
        pulse_start(8'h60, 9'd3, 4'd4, 1'b1);
        n = 0;
        while (words - w0 < 5 && n < 100) begin
            tick();
            n++;
        end
        check("rst_reached_5_words", 32'(words - w0 >= 5), 32'd1);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        exp_q.delete();
        tick();
        check_all_zero("midrst");
        repeat (10) tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        // Fresh region after the abort
        d0 = done_cnt;
        push_region(112, 2, 2);
        pulse_start(8'h70, 9'd2, 4'd2, 1'b1);
        wait_done(d0, 200);
        check("fresh_first_valid_cycle", 32'(first_valid_rel), 32'd3);
        check("fresh_done_cycle", 32'(done_rel), 32'd7);
        check("fresh_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
